// File: rtl/fu_execute_cluster.sv
// Three-lane execute cluster: lanes 0/1 are single-cycle ALUs, lane 2 adds a
// load/store path driven by an IDLE -> MEM -> RESP handshake FSM.
module fu_execute_cluster #(
  parameter int AR_SIZE  = 6,
  parameter int FU_ARRAY = 3
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [2:0]         tunnel_in,
  input  logic [3:0]         op_in0,
  input  logic [3:0]         op_in1,
  input  logic [3:0]         op_in2,
  input  logic [AR_SIZE-1:0] rd_in0,
  input  logic [AR_SIZE-1:0] rd_in1,
  input  logic [AR_SIZE-1:0] rd_in2,
  input  logic [31:0]        rs1_value_in0,
  input  logic [31:0]        rs1_value_in1,
  input  logic [31:0]        rs1_value_in2,
  input  logic [31:0]        rs2_value_in0,
  input  logic [31:0]        rs2_value_in1,
  input  logic [31:0]        rs2_value_in2,
  input  logic [31:0]        imm_value_in0,
  input  logic [31:0]        imm_value_in1,
  input  logic [31:0]        imm_value_in2,
  output logic [2:0]         fu_ready_out,
  output logic               FU0_flag_out,
  output logic               FU1_flag_out,
  output logic               FU2_flag_out,
  output logic [AR_SIZE-1:0] reg_tag_from_FU0_out,
  output logic [AR_SIZE-1:0] reg_tag_from_FU1_out,
  output logic [AR_SIZE-1:0] reg_tag_from_FU2_out,
  output logic [31:0]        reg_value_from_FU0_out,
  output logic [31:0]        reg_value_from_FU1_out,
  output logic [31:0]        reg_value_from_FU2_out,
  output logic               mem_req_out,
  output logic               mem_we_out,
  output logic [1:0]         mem_size_out,
  output logic [31:0]        mem_addr_out,
  output logic [31:0]        mem_wdata_out,
  input  logic               mem_ack_in,
  input  logic [31:0]        mem_rdata_in,
  output logic               err_out
);

  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_ADDI = 4'd2;
  localparam logic [3:0] OP_LUI  = 4'd3;
  localparam logic [3:0] OP_ORI  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SRAI = 4'd6;
  localparam logic [3:0] OP_LB   = 4'd7;
  localparam logic [3:0] OP_LW   = 4'd8;
  localparam logic [3:0] OP_SB   = 4'd9;
  localparam logic [3:0] OP_SW   = 4'd10;

  if (FU_ARRAY != 3) begin : g_lane_check
    $error("fu_execute_cluster is built for exactly three lanes");
  end

  typedef enum logic [1:0] {S_IDLE, S_MEM, S_RESP} state_t;

  function automatic logic op_is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SRAI);
  endfunction

  function automatic logic op_is_mem(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic [31:0] alu_calc(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] imm);
    logic signed [31:0] sa;
    logic [31:0]        res;
    sa = signed'(a);
    case (op)
      OP_ADD:  res = a + b;
      OP_ADDI: res = a + imm;
      OP_LUI:  res = imm;
      OP_ORI:  res = a | imm;
      OP_XOR:  res = a ^ b;
      OP_SRAI: res = 32'(sa >>> imm[4:0]);
      default: res = '0;
    endcase
    return res;
  endfunction

  logic [3:0]         w_op  [3];
  logic [AR_SIZE-1:0] w_rd  [3];
  logic [31:0]        w_rs1 [3];
  logic [31:0]        w_rs2 [3];
  logic [31:0]        w_imm [3];

  assign w_op  = '{op_in0, op_in1, op_in2};
  assign w_rd  = '{rd_in0, rd_in1, rd_in2};
  assign w_rs1 = '{rs1_value_in0, rs1_value_in1, rs1_value_in2};
  assign w_rs2 = '{rs2_value_in0, rs2_value_in1, rs2_value_in2};
  assign w_imm = '{imm_value_in0, imm_value_in1, imm_value_in2};

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_flag;
  logic [AR_SIZE-1:0] r_tag [3];
  logic [31:0]        r_val [3];
  logic               r_req, r_we, r_ld, r_err, r_alive;
  logic [1:0]         r_size;
  logic [31:0]        r_addr, r_wdata;
  logic [AR_SIZE-1:0] r_mem_tag;

  logic [2:0]  w_ok, w_alu_fire;
  logic        w_mem_fire, w_err, w_ack_take;
  logic [31:0] w_load_val;

  // Issue legality: lanes 0/1 take ALU ops only; lane 2 takes anything legal, but only in IDLE
  always_comb begin
    w_ok       = '0;
    w_alu_fire = '0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2)
        w_ok[i] = tunnel_in[i] && (r_state == S_IDLE) &&
                  (op_is_alu(w_op[i]) || op_is_mem(w_op[i]));
      else
        w_ok[i] = tunnel_in[i] && op_is_alu(w_op[i]);
      w_alu_fire[i] = w_ok[i] && op_is_alu(w_op[i]);
    end
    w_mem_fire = w_ok[2] && op_is_mem(w_op[2]);
    w_err      = |(tunnel_in & ~w_ok);
    w_ack_take = (r_state == S_MEM) && mem_ack_in;
    w_load_val = (r_size == 2'd0) ? {{24{mem_rdata_in[7]}}, mem_rdata_in[7:0]} : mem_rdata_in;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (w_mem_fire) w_state_nxt = S_MEM;
      S_MEM:   if (mem_ack_in) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_alive <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_alive <= 1'b1;
      r_err   <= w_err;
    end
  end

  // Result broadcast: ALU results one cycle after issue, load data in the RESP cycle
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_flag <= '0;
      for (int i = 0; i < 3; i++) begin
        r_tag[i] <= '0;
        r_val[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        r_flag[i] <= w_alu_fire[i];
        if (w_alu_fire[i]) begin
          r_tag[i] <= w_rd[i];
          r_val[i] <= alu_calc(w_op[i], w_rs1[i], w_rs2[i], w_imm[i]);
        end
      end
      if (w_ack_take && r_ld) begin
        r_flag[2] <= 1'b1;
        r_tag[2]  <= r_mem_tag;
        r_val[2]  <= w_load_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_req     <= 1'b0;
      r_we      <= 1'b0;
      r_ld      <= 1'b0;
      r_size    <= '0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_mem_tag <= '0;
    end else if (w_mem_fire) begin
      r_req     <= 1'b1;
      r_we      <= (w_op[2] == OP_SB) || (w_op[2] == OP_SW);
      r_ld      <= (w_op[2] == OP_LB) || (w_op[2] == OP_LW);
      r_size    <= ((w_op[2] == OP_LB) || (w_op[2] == OP_SB)) ? 2'd0 : 2'd2;
      r_addr    <= w_rs1[2] + w_imm[2];
      r_wdata   <= (w_op[2] == OP_SB) ? {24'h0, w_rs2[2][7:0]} : w_rs2[2];
      r_mem_tag <= w_rd[2];
    end else if (w_ack_take) begin
      r_req <= 1'b0;
    end
  end

  assign fu_ready_out           = {r_alive && (r_state == S_IDLE), r_alive, r_alive};
  assign FU0_flag_out           = r_flag[0];
  assign FU1_flag_out           = r_flag[1];
  assign FU2_flag_out           = r_flag[2];
  assign reg_tag_from_FU0_out   = r_tag[0];
  assign reg_tag_from_FU1_out   = r_tag[1];
  assign reg_tag_from_FU2_out   = r_tag[2];
  assign reg_value_from_FU0_out = r_val[0];
  assign reg_value_from_FU1_out = r_val[1];
  assign reg_value_from_FU2_out = r_val[2];
  assign mem_req_out            = r_req;
  assign mem_we_out             = r_we;
  assign mem_size_out           = r_size;
  assign mem_addr_out           = r_addr;
  assign mem_wdata_out          = r_wdata;
  assign err_out                = r_err;

endmodule

// File: tb/tb_fu_execute_cluster.sv
// Bench for fu_execute_cluster: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_fu_execute_cluster;
  localparam int AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn;
  logic [2:0]    t_tunnel;
  logic [3:0]    t_op  [3];
  logic [AW-1:0] t_rd  [3];
  logic [31:0]   t_rs1 [3];
  logic [31:0]   t_rs2 [3];
  logic [31:0]   t_imm [3];
  logic          t_ack;
  logic [31:0]   t_rdata;

  logic [2:0]    fu_ready_out;
  logic          f0, f1, f2;
  logic [AW-1:0] tg0, tg1, tg2;
  logic [31:0]   v0, v1, v2;
  logic          mem_req_out, mem_we_out, err_out;
  logic [1:0]    mem_size_out;
  logic [31:0]   mem_addr_out, mem_wdata_out;

  fu_execute_cluster #(.AR_SIZE(AW), .FU_ARRAY(3)) dut (
    .clk(clk), .rstn(rstn), .tunnel_in(t_tunnel),
    .op_in0(t_op[0]), .op_in1(t_op[1]), .op_in2(t_op[2]),
    .rd_in0(t_rd[0]), .rd_in1(t_rd[1]), .rd_in2(t_rd[2]),
    .rs1_value_in0(t_rs1[0]), .rs1_value_in1(t_rs1[1]), .rs1_value_in2(t_rs1[2]),
    .rs2_value_in0(t_rs2[0]), .rs2_value_in1(t_rs2[1]), .rs2_value_in2(t_rs2[2]),
    .imm_value_in0(t_imm[0]), .imm_value_in1(t_imm[1]), .imm_value_in2(t_imm[2]),
    .fu_ready_out(fu_ready_out),
    .FU0_flag_out(f0), .FU1_flag_out(f1), .FU2_flag_out(f2),
    .reg_tag_from_FU0_out(tg0), .reg_tag_from_FU1_out(tg1), .reg_tag_from_FU2_out(tg2),
    .reg_value_from_FU0_out(v0), .reg_value_from_FU1_out(v1), .reg_value_from_FU2_out(v2),
    .mem_req_out(mem_req_out), .mem_we_out(mem_we_out), .mem_size_out(mem_size_out),
    .mem_addr_out(mem_addr_out), .mem_wdata_out(mem_wdata_out),
    .mem_ack_in(t_ack), .mem_rdata_in(t_rdata), .err_out(err_out)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: one outstanding memory transaction plus expected broadcasts
  bit            m_busy, m_resp, m_ld, m_we;
  logic [1:0]    m_size;
  logic [31:0]   m_addr, m_wdata;
  logic [AW-1:0] m_tag;
  logic [2:0]    e_flag, e_ready;
  logic          e_err;
  logic [AW-1:0] e_tag [3];
  logic [31:0]   e_val [3];

  function automatic logic [31:0] ref_alu(input int op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] imm);
    logic [31:0] r;
    case (op)
      1: r = a + b;
      2: r = a + imm;
      3: r = imm;
      4: r = a | imm;
      5: r = a ^ b;
      6: begin
        r = a;
        for (int k = 0; k < int'(imm[4:0]); k++) r = {r[31], r[31:1]};
      end
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_resp = 0; m_ld = 0; m_we = 0; m_size = 0; m_addr = 0; m_wdata = 0;
    e_flag = 0; e_ready = 0; e_err = 0;
  endtask

  task automatic model_edge();
    bit idle;
    int op;
    if (!rstn) begin
      model_reset();
      return;
    end
    idle   = !(m_busy || m_resp);
    e_flag = 0;
    e_err  = 0;
    if (m_resp) m_resp = 0;
    else if (m_busy && t_ack) begin
      m_busy = 0;
      m_resp = 1;
      if (m_ld) begin
        e_flag[2] = 1;
        e_tag[2]  = m_tag;
        e_val[2]  = (m_size == 0) ? {{24{t_rdata[7]}}, t_rdata[7:0]} : t_rdata;
      end
    end
    for (int i = 0; i < 3; i++) begin
      if (t_tunnel[i]) begin
        op = int'(t_op[i]);
        if (op >= 1 && op <= 6 && (i < 2 || idle)) begin
          e_flag[i] = 1;
          e_tag[i]  = t_rd[i];
          e_val[i]  = ref_alu(op, t_rs1[i], t_rs2[i], t_imm[i]);
        end else if (op >= 7 && op <= 10 && i == 2 && idle) begin
          m_busy  = 1;
          m_addr  = t_rs1[i] + t_imm[i];
          m_we    = (op >= 9);
          m_ld    = (op <= 8);
          m_size  = (op == 7 || op == 9) ? 2'd0 : 2'd2;
          m_wdata = (op == 9) ? {24'h0, t_rs2[i][7:0]} : t_rs2[i];
          m_tag   = t_rd[i];
        end else begin
          e_err = 1;
        end
      end
    end
    e_ready = {!(m_busy || m_resp), 2'b11};
  endtask

  always @(negedge clk) begin
    chk("ready", fu_ready_out, e_ready);
    chk("err", err_out, e_err);
    chk("flags", {f2, f1, f0}, e_flag);
    if (e_flag[0]) begin chk("tag0", tg0, e_tag[0]); chk("val0", v0, e_val[0]); end
    if (e_flag[1]) begin chk("tag1", tg1, e_tag[1]); chk("val1", v1, e_val[1]); end
    if (e_flag[2]) begin chk("tag2", tg2, e_tag[2]); chk("val2", v2, e_val[2]); end
    chk("mem_req", mem_req_out, m_busy);
    if (m_busy) begin
      chk("mem_addr", mem_addr_out, m_addr);
      chk("mem_we", mem_we_out, m_we);
      chk("mem_size", mem_size_out, m_size);
      chk("mem_wdata", mem_wdata_out, m_wdata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    model_edge();
    t_tunnel = '0;
    t_ack    = 1'b0;
  endtask

  task automatic probe();
    @(negedge clk);
    #1;
  endtask

  task automatic issue(input int lane, input logic [3:0] op, input logic [AW-1:0] rd,
                       input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
    t_tunnel[lane] = 1'b1;
    t_op[lane]  = op;
    t_rd[lane]  = rd;
    t_rs1[lane] = rs1;
    t_rs2[lane] = rs2;
    t_imm[lane] = imm;
  endtask

  initial begin
    rstn = 1'b0;
    t_tunnel = '0; t_ack = 1'b0; t_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      t_op[i] = '0; t_rd[i] = '0; t_rs1[i] = '0; t_rs2[i] = '0; t_imm[i] = '0;
      e_tag[i] = '0; e_val[i] = '0;
    end
    m_tag = '0;
    model_reset();
    probe();
    chk("rst_ready", fu_ready_out, 32'h0);
    chk("rst_req", mem_req_out, 32'h0);
    @(posedge clk); #2 rstn = 1'b1;
    tick();
    probe();
    chk("ready_after_rst", fu_ready_out, 32'h7);

    // Three lanes at once
    issue(0, 4'd1, 3, 5, 7, 0);
    issue(1, 4'd5, 4, 32'hF0, 32'hFF, 0);
    issue(2, 4'd6, 5, 32'h80000000, 0, 4);
    tick(); probe();
    chk("d_flags", {f2, f1, f0}, 32'h7);
    chk("d_tag0", tg0, 3); chk("d_val0", v0, 12);
    chk("d_tag1", tg1, 4); chk("d_val1", v1, 32'h0F);
    chk("d_tag2", tg2, 5); chk("d_val2", v2, 32'hF8000000);

    // LB with delayed ack
    issue(2, 4'd7, 9, 32'h100, 0, 4);
    tick(); probe();
    chk("lb_req", mem_req_out, 1); chk("lb_addr", mem_addr_out, 32'h104);
    chk("lb_size", mem_size_out, 0); chk("lb_ready", fu_ready_out, 32'h3);
    tick(); tick(); probe();
    chk("lb_req_hold", mem_req_out, 1);
    t_ack = 1'b1; t_rdata = 32'h80;
    tick(); probe();
    chk("lb_flag", f2, 1); chk("lb_tag", tg2, 9); chk("lb_val", v2, 32'hFFFFFF80);
    chk("lb_req_drop", mem_req_out, 0); chk("lb_ready_resp", fu_ready_out, 32'h3);
    tick(); probe();
    chk("lb_ready_back", fu_ready_out, 32'h7); chk("lb_flag_off", f2, 0);

    // SW with address wrap
    issue(2, 4'd10, 0, 32'hFFFFFFFC, 32'h12345678, 8);
    tick(); probe();
    chk("sw_addr", mem_addr_out, 32'h4); chk("sw_we", mem_we_out, 1);
    chk("sw_size", mem_size_out, 2); chk("sw_wdata", mem_wdata_out, 32'h12345678);
    t_ack = 1'b1;
    tick(); probe();
    chk("sw_noflag", f2, 0);
    tick(); probe();
    chk("sw_ready", fu_ready_out, 32'h7);

    // Illegal issues while a load is pending
    issue(2, 4'd8, 7, 32'h200, 0, 0);
    tick();
    issue(2, 4'd1, 1, 1, 1, 0);
    issue(0, 4'd8, 2, 0, 0, 0);
    tick(); probe();
    chk("ill_err", err_out, 1); chk("ill_flags", {f2, f1, f0}, 0);
    chk("ill_req", mem_req_out, 1); chk("ill_addr", mem_addr_out, 32'h200);
    issue(1, 4'd0, 1, 0, 0, 0);
    issue(0, 4'd12, 1, 0, 0, 0);
    tick(); probe();
    chk("badop_err", err_out, 1); chk("badop_flags", {f2, f1, f0}, 0);
    tick(); probe();
    chk("err_clear", err_out, 0);
    t_ack = 1'b1; t_rdata = 32'hDEADBEEF;
    tick(); probe();
    chk("lw_flag", f2, 1); chk("lw_tag", tg2, 7); chk("lw_val", v2, 32'hDEADBEEF);
    tick();

    // Reset during MEM
    issue(2, 4'd8, 3, 32'h40, 0, 0);
    tick(); probe();
    chk("mr_req", mem_req_out, 1);
    #1 rstn = 1'b0;
    model_reset();
    #1;
    chk("mr_req_drop", mem_req_out, 0); chk("mr_ready", fu_ready_out, 0);
    @(posedge clk); #2 rstn = 1'b1;
    t_ack = 1'b1;
    tick(); probe();
    chk("mr_ready_back", fu_ready_out, 32'h7); chk("mr_noflag", {f2, f1, f0}, 0);

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      t_tunnel = 3'($urandom);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 9) < 8)
          t_op[i] = (i == 2) ? 4'($urandom_range(1, 10)) : 4'($urandom_range(1, 6));
        else
          t_op[i] = 4'($urandom_range(0, 15));
        t_rd[i]  = AW'($urandom);
        t_rs1[i] = $urandom;
        t_rs2[i] = $urandom;
        t_imm[i] = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 40));
      end
      t_ack   = ($urandom_range(0, 3) == 0);
      t_rdata = $urandom;
      tick();
      if ($urandom_range(0, 299) == 0) begin
        #1 rstn = 1'b0;
        model_reset();
        @(posedge clk); #2 rstn = 1'b1;
      end
    end
    probe();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fu_execute_cluster.md
FU_EXECUTE_CLUSTER -- requirements
Module: fu_execute_cluster

Interface
REQ-001 SHALL have parameter AR_SIZE, default 6, giving the physical register tag width.
REQ-002 SHALL have parameter FU_ARRAY, default 3, giving the lane count; lanes 0 and 1 are ALU-only, lane 2 is ALU plus load/store.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port tunnel_in, input, 3 bits: bit i high issues one instruction to lane i this cycle.
REQ-006 SHALL have ports op_in0/1/2, input, 4 bits each: operation code, with ADD=1, ADDI=2, LUI=3, ORI=4, XOR=5, SRAI=6, LB=7, LW=8, SB=9, SW=10.
REQ-007 SHALL have ports rd_in0/1/2, input, AR_SIZE each: destination tag.
REQ-008 SHALL have ports rs1_value_in0/1/2, rs2_value_in0/1/2 and imm_value_in0/1/2, input, 32 bits each: operand values.
REQ-009 SHALL have port fu_ready_out, output, 3 bits: bit i high means lane i accepts an issue this cycle.
REQ-010 SHALL have ports FU0/1/2_flag_out (1 bit), reg_tag_from_FU0/1/2_out (AR_SIZE) and reg_value_from_FU0/1/2_out (32 bits), all outputs: the result broadcast.
REQ-011 SHALL have memory request outputs: mem_req_out (1), mem_we_out (1), mem_size_out (2; 0 = byte, 2 = word), mem_addr_out (32), mem_wdata_out (32).
REQ-012 SHALL have memory response inputs: mem_ack_in (1) and mem_rdata_in (32).
REQ-013 SHALL have port err_out, output, 1 bit: one-cycle pulse on an illegal issue.

Function
REQ-014 SHALL, for ALU ops on any lane issued at edge N, drive FUi_flag_out high for exactly the cycle after edge N, with tag = rd and the registered result.
- 1-cycle latency.
- Flag is low when no result.
REQ-015 SHALL compute results mod 2^32 as follows:
- ADD = rs1+rs2; ADDI = rs1+imm.
- LUI = imm (imm is pre-shifted).
- ORI = rs1|imm; XOR = rs1^rs2.
- SRAI = rs1 arithmetic-shifted right by imm[4:0].
REQ-016 SHALL hold fu_ready_out[0] and fu_ready_out[1] at 1 at all times out of reset.
REQ-017 SHALL run lane 2 as FSM IDLE -> MEM -> RESP -> IDLE; fu_ready_out[2] = (state == IDLE).
REQ-018 SHALL, in IDLE on a lane-2 memory op:
- latch mem_addr_out = rs1+imm (wrap mod 2^32);
- set mem_we_out = 1 for SB/SW, else 0;
- set mem_size_out = 0 for LB/SB, 2 for LW/SW;
- set mem_wdata_out = rs2 (SB: rs2[7:0] zero-extended);
- go to MEM with mem_req_out = 1 from the next cycle.
REQ-019 SHALL, in MEM, hold mem_req_out and all request fields stable until a cycle with mem_ack_in = 1; at that edge drop mem_req_out and enter RESP.
REQ-020 SHALL, in RESP, assert FU2_flag_out for one cycle for loads, then return to IDLE.
- LW value = mem_rdata_in latched at the ack edge.
- LB value = sign-extended mem_rdata_in[7:0].
- Stores raise no flag; they spend RESP silently.
REQ-021 SHALL process an ALU op issued to lane 2 while IDLE with the 1-cycle path of REQ-014, staying in IDLE.
REQ-022 SHALL treat the following as illegal issues: drop the instruction, raise no flag, pulse err_out for one cycle, leave state unchanged:
- issue to lane 2 while not IDLE;
- memory op issued to lane 0 or 1;
- op 0 or op >10.
REQ-023 SHALL handle simultaneous issues on all three lanes independently in the same cycle.
REQ-024 SHALL ignore mem_ack_in outside MEM.

Reset
REQ-025 SHALL, while rstn = 0, asynchronously force:
- all flags, tags, values, mem_* outputs, err_out and fu_ready_out to 0;
- lane-2 state to IDLE.
REQ-026 SHALL drive fu_ready_out = 3'b111 from the first edge after rstn deasserts.
REQ-027 SHALL, on reset during MEM or RESP, abandon the transaction: mem_req_out falls immediately and no result is broadcast.

Verification
REQ-028 SHALL cover: tunnel_in = 3'b111; lane0 ADD 5+7 rd=3; lane1 XOR 0xF0^0xFF rd=4; lane2 SRAI 0x80000000 imm=4 rd=5 -> next cycle flags 1/1/1 with (3,12), (4,0x0F), (5,0xF8000000).
REQ-029 SHALL cover: lane2 LB rs1=0x100 imm=4 rd=9 -> mem_req_out = 1, addr 0x104, size 0; ack after 3 cycles with rdata 0x80 -> FU2 flag with (9,0xFFFFFF80); fu_ready_out[2] low from issue+1 until IDLE.
REQ-030 SHALL cover: lane2 SW rs1=0xFFFFFFFC imm=8 -> addr 0x4 (wrap), we = 1; after ack no FU2 flag; ready returns to 1.
REQ-031 SHALL cover: issue to lane 2 during MEM, plus LW on lane 0 -> err_out pulses, no extra flags, pending transaction unaffected.
REQ-032 SHALL cover: rstn low while in MEM -> mem_req_out = 0 immediately; after release fu_ready_out = 3'b111 and no stale flag.
